// File: rtl/i2s_mic_receiver.sv
// I2S MEMS microphone front end: generates mic_bclk/mic_ws from clk and
// deserialises one channel slot into a signed DATA_BITS sample with a new_t strobe.
module i2s_mic_receiver #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 18,
  parameter int SLOT_BITS = 32,
  parameter int CHANNEL   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mic_sd,
  output logic                 mic_bclk,
  output logic                 mic_ws,
  output logic [DATA_BITS-1:0] t,
  output logic                 new_t
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_START = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             SEL_RIGHT  = (CHANNEL != 0);

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;

  logic                 tick;
  logic                 rise_evt;
  logic                 fall_evt;
  logic [BIT_W-1:0]     bit_cnt_next;
  logic [BIT_W-1:0]     bit_cnt_after;
  logic                 ws_next;
  logic                 in_right;
  logic [BIT_W-1:0]     pos;
  logic                 slot_hit;
  logic                 capture;
  logic                 publish;
  logic [DATA_BITS-1:0] shift_in;

  // Events are decoded from the pre-edge state, so they mark the very clk
  // edge on which mic_bclk toggles.
  assign tick     = (div_cnt == DIV_LAST);
  assign rise_evt = tick & ~mic_bclk;
  assign fall_evt = tick & mic_bclk;

  assign bit_cnt_next  = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
  assign bit_cnt_after = (bit_cnt_next == BIT_LAST) ? '0 : bit_cnt_next + BIT_W'(1);
  // ws leads the slot by one bclk so the I2S one-bit delay lands the MSB on pos 0.
  assign ws_next       = (bit_cnt_after >= SLOT_START);

  assign in_right = (bit_cnt >= SLOT_START);
  assign pos      = in_right ? (bit_cnt - SLOT_START) : bit_cnt;
  assign slot_hit = (in_right == SEL_RIGHT);
  assign capture  = rise_evt & slot_hit & (pos <= DATA_LAST);
  assign publish  = rise_evt & slot_hit & (pos == DATA_LAST);
  assign shift_in = {shift[DATA_BITS-2:0], mic_sd};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      mic_bclk <= 1'b0;
      mic_ws   <= 1'b0;
      t        <= '0;
      new_t    <= 1'b0;
    end else if (!en) begin
      // NOTE: idle clears the interface but keeps t, so downstream still
      // holds the last good sample while the microphone is stopped.
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      mic_bclk <= 1'b0;
      mic_ws   <= 1'b0;
      new_t    <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      new_t   <= publish;
      if (tick) begin
        mic_bclk <= ~mic_bclk;
      end
      if (fall_evt) begin
        bit_cnt <= bit_cnt_next;
        mic_ws  <= ws_next;
      end
      if (capture) begin
        shift <= shift_in;
      end
      if (publish) begin
        t <= shift_in;
      end
    end
  end

endmodule

// File: tb/tb_i2s_mic_receiver.sv
// Self-checking bench: two receivers (fast left, default-rate right) fed by a
// behavioural I2S microphone and compared every clk against frame arithmetic.
module tb_i2s_mic_receiver;

  localparam int DB  = 18;
  localparam int SB  = 32;
  localparam int NF  = 8;
  localparam int CD0 = 2;
  localparam int CD1 = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sd0, sd1;
  logic          bclk0, bclk1, ws0, ws1, new0, new1;
  logic [DB-1:0] t0, t1;

  i2s_mic_receiver #(.CLK_DIV(CD0), .DATA_BITS(DB), .SLOT_BITS(SB), .CHANNEL(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mic_sd(sd0),
    .mic_bclk(bclk0), .mic_ws(ws0), .t(t0), .new_t(new0)
  );

  i2s_mic_receiver #(.CLK_DIV(CD1), .DATA_BITS(DB), .SLOT_BITS(SB), .CHANNEL(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mic_sd(sd1),
    .mic_bclk(bclk1), .mic_ws(ws1), .t(t1), .new_t(new1)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            passes = 0;
  int            fails  = 0;
  int            n      = 0;          // enabled clk edges since the last clear
  int            last_pulse = -1;     // n of the previous observed dut1 pulse
  logic [DB-1:0] wl [2][NF];          // left-slot words per dut, per frame
  logic [DB-1:0] wr [2][NF];          // right-slot words per dut, per frame
  logic [DB-1:0] exp_t [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Microphone: period k carries slot (k%64)/32, pos k%32 of frame k/64.
  function automatic logic word_bit(input int d, input int k);
    int            slot, pos, f;
    logic [DB-1:0] w;
    slot = (k % (2 * SB)) / SB;
    pos  = k % SB;
    f    = (k / (2 * SB)) % NF;
    w    = (slot == 1) ? wr[d][f] : wl[d][f];
    if (pos < DB) return w[DB-1-pos];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic tick();
    int   cd, k, ph;
    logic pulse;
    @(posedge clk);
    #1;
    if (rst) begin
      n = 0;
      exp_t[0] = '0;
      exp_t[1] = '0;
      last_pulse = -1;
    end else if (!en) begin
      n = 0;
      last_pulse = -1;
    end else begin
      n++;
    end
    for (int d = 0; d < 2; d++) begin
      cd    = (d == 1) ? CD1 : CD0;
      k     = n / (2 * cd);
      ph    = n % (2 * cd);
      pulse = (n > 0) && (ph == cd) && (((k % (2 * SB)) / SB) == d) && ((k % SB) == DB - 1);
      if (pulse) exp_t[d] = (d == 1) ? wr[d][(k / (2 * SB)) % NF] : wl[d][(k / (2 * SB)) % NF];
      if (d == 0) begin
        check("bclk0", 32'(bclk0), 32'((n / cd) % 2));
        check("ws0", 32'(ws0), 32'(((k + 1) % (2 * SB)) >= SB));
        check("new_t0", 32'(new0), 32'(pulse));
        check("t0", 32'(t0), 32'(exp_t[0]));
        if (ph == 0) sd0 = word_bit(0, k);
      end else begin
        check("bclk1", 32'(bclk1), 32'((n / cd) % 2));
        check("ws1", 32'(ws1), 32'(((k + 1) % (2 * SB)) >= SB));
        check("new_t1", 32'(new1), 32'(pulse));
        check("t1", 32'(t1), 32'(exp_t[1]));
        if (new1 === 1'b1) begin
          if (last_pulse >= 0) check("pulse_spacing", 32'(n - last_pulse), 32'd2048);
          last_pulse = n;
        end
        if (ph == 0) sd1 = word_bit(1, k);
      end
    end
  endtask

  initial begin
    logic [DB-1:0] held;
    for (int d = 0; d < 2; d++) begin
      for (int f = 0; f < NF; f++) begin
        wl[d][f] = DB'($urandom);
        wr[d][f] = DB'($urandom);
      end
    end
    wl[0][0] = 18'h2A5A5;  wr[0][0] = 18'h3FFFF;
    wl[0][1] = 18'h20001;  wr[0][1] = 18'h1FFFF;
    wl[1][0] = 18'h1FFFF;  wr[1][0] = 18'h20001;
    wl[1][1] = 18'h00000;  wr[1][1] = 18'h1FFFF;
    exp_t[0] = '0;
    exp_t[1] = '0;
    sd0 = 1'b0;
    sd1 = 1'b0;

    // Reset held three cycles with en high.
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Left capture on the fast receiver, then right capture on the default one.
    repeat (100) tick();
    check("t0_left_2a5a5", 32'(t0), 32'h2A5A5);
    repeat (1500) tick();
    check("t1_right_20001", 32'(t1), 32'h20001);
    repeat (2600) tick();
    check("t1_right_1ffff", 32'(t1), 32'h1FFFF);

    // Drop en at slot-0 pos 9 of the fast receiver.
    while (((n / (2 * CD0)) % (2 * SB)) != 9) tick();
    held = exp_t[0];
    en = 1'b0;
    repeat (20) tick();
    check("abort_t0_hold", 32'(t0), 32'(held));
    en = 1'b1;
    repeat (600) tick();
    check("t0_after_abort", 32'(t0), 32'(wl[0][2]));

    // Reset at slot-0 pos 10, mid capture.
    while (((n / (2 * CD0)) % (2 * SB)) != 10) tick();
    rst = 1'b1;
    repeat (2) tick();
    check("rst_mid_t0", 32'(t0), 32'h0);
    rst = 1'b0;
    repeat (4400) tick();
    check("t0_after_rst", 32'(t0), 32'(wl[0][((4400 - 70) / 256) % NF]));
    check("t1_after_rst", 32'(t1), 32'(wr[1][1]));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
